// File: rtl/regfile_pkg.sv
// Shared sizing, requester indices and the writeback request record for the
// register-file writeback path.
package regfile_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int ADDRESS_WIDTH = 5;
    localparam int NUM_REGS      = 32;
    localparam int NUM_REQ       = 3;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] dest;
        logic [DATA_WIDTH-1:0]    data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] sel;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sel = IDX_W'((32'(rr_ptr) + k) % 32'(NUM_REQ));
            if (!found && req_valid[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the register-file write port plus the busy scoreboard
// that decode uses to stall RAW/WAW hazards on in-flight results.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH    = regfile_pkg::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = regfile_pkg::ADDRESS_WIDTH,
    parameter int NUM_REGS      = regfile_pkg::NUM_REGS,
    parameter int NUM_REQ       = regfile_pkg::NUM_REQ
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_dest,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic                             rg_wrt_en,
    output logic [ADDRESS_WIDTH-1:0]         rg_wrt_dest,
    output logic [DATA_WIDTH-1:0]            rg_wrt_data,
    input  logic                             iss_valid,
    input  logic [ADDRESS_WIDTH-1:0]         iss_dest,
    output logic                             iss_ready,
    input  logic [ADDRESS_WIDTH-1:0]         rs1_addr,
    input  logic [ADDRESS_WIDTH-1:0]         rs2_addr,
    output logic                             rs1_busy,
    output logic                             rs2_busy,
    output logic [NUM_REGS-1:0]              busy_vec
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         grant_idx;
    logic [NUM_REQ-1:0]       grant;
    logic                     transfer;
    logic [ADDRESS_WIDTH-1:0] xfer_dest;
    logic [DATA_WIDTH-1:0]    xfer_data;
    logic [NUM_REGS-1:0]      busy_q;
    logic [NUM_REGS-1:0]      busy_nxt;
    logic                     iss_set;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = rst ? '0 : grant;
    assign transfer  = |req_ready;
    assign xfer_dest = req_dest[32'(grant_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign xfer_data = req_data[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];

    // A destination being written back this cycle is already free for
    // reissue and for source reads, since the regfile commits at negedge.
    assign iss_ready = !rst && ((iss_dest == '0) || !busy_q[iss_dest] ||
                                (transfer && (xfer_dest == iss_dest)));
    assign rs1_busy  = busy_q[rs1_addr] && !(transfer && (xfer_dest == rs1_addr));
    assign rs2_busy  = busy_q[rs2_addr] && !(transfer && (xfer_dest == rs2_addr));
    assign iss_set   = iss_valid && iss_ready && (iss_dest != '0);
    assign busy_vec  = busy_q;

    always_comb begin
        busy_nxt = busy_q;
        if (transfer) begin
            busy_nxt[xfer_dest] = 1'b0;
        end
        if (iss_set) begin
            busy_nxt[iss_dest] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr      <= IDX_W'(REQ_ALU);
            busy_q      <= '0;
            rg_wrt_en   <= 1'b0;
            rg_wrt_dest <= '0;
            rg_wrt_data <= '0;
        end else begin
            busy_q    <= busy_nxt;
            rg_wrt_en <= 1'b0;
            if (transfer) begin
                rr_ptr      <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
                rg_wrt_en   <= (xfer_dest != '0);
                rg_wrt_dest <= xfer_dest;
                rg_wrt_data <= xfer_data;
            end
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port between N writeback requesters (default ALU, LSU, MUL/DIV) using registered round-robin arbitration. It also holds a per-register busy scoreboard that the decode stage uses to stall RAW/WAW hazards on in-flight multi-cycle results. It sits between the execute-side units and the register file write port. The register file writes on negedge clk; this block updates on posedge clk.

Parameters:
DATA_WIDTH, 32, register data width
ADDRESS_WIDTH, 5, register address width
NUM_REGS, 32, number of architectural registers
NUM_REQ, 3, number of writeback requesters (index 0 = ALU)

Ports:
clk  in  1  clock, posedge
rst  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  requester i has a result
req_dest  in  NUM_REQ*ADDRESS_WIDTH  destination of requester i, packed with i at the LSBs
req_data  in  NUM_REQ*DATA_WIDTH  result of requester i, packed
req_ready  out  NUM_REQ  grant, one-hot or zero
rg_wrt_en  out  1  register-file write enable
rg_wrt_dest  out  ADDRESS_WIDTH  register-file write address
rg_wrt_data  out  DATA_WIDTH  register-file write data
iss_valid  in  1  decode is issuing an instruction that will write iss_dest
iss_dest  in  ADDRESS_WIDTH  destination of the issuing instruction
iss_ready  out  1  issue accepted (no WAW conflict)
rs1_addr, rs2_addr  in  ADDRESS_WIDTH each  decode source addresses
rs1_busy, rs2_busy  out  1 each  source has a pending write
busy_vec  out  NUM_REGS  scoreboard state, for debug

Behaviour:
- Reset (rst=1 at posedge): rg_wrt_en=0, rg_wrt_dest=0, rg_wrt_data=0, rr_ptr=0, busy_vec=0.
- While rst=1: req_ready=0 and iss_ready=0. Requests and issues are ignored.
- Reset mid-operation discards all pending requests and scoreboard state. Requesters must re-present after reset.
- Grant (combinational):
  - Grant the first i with req_valid[i]=1, searching i=rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[i]=1 for that i only. No valid requests gives all-zero.
- A transfer occurs on req_valid[i] & req_ready[i]. Requesters hold valid, dest and data stable until granted.
- Pointer update: on a transfer by i, rr_ptr <= (i+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Output stage, registered, 1-cycle latency:
  - On a transfer, rg_wrt_dest/rg_wrt_data <= granted dest/data.
  - rg_wrt_en <= (dest != 0). Writes to x0 are accepted but never enable the register file.
  - With no transfer, rg_wrt_en <= 0 and dest/data hold their previous values.
  - The register file commits at the following negedge, so data is readable in the same cycle rg_wrt_en is high.
- Scoreboard:
  - Set: iss_valid & iss_ready & iss_dest!=0 sets busy[iss_dest] at posedge.
  - Clear: a transfer with dest d clears busy[d] at the same posedge the output stage loads.
  - If set and clear hit the same register in one cycle, set wins.
  - busy[0] is always 0.
  - iss_ready = !rst & (iss_dest==0 | !busy[iss_dest] | clr_hit), where clr_hit = this cycle's transfer dest equals iss_dest. This allows back-to-back reuse of a destination.
  - rsN_busy = busy[rsN_addr] & !(transfer dest == rsN_addr). Rs busy is released in the grant cycle because the value lands at the next negedge, before decode samples it.
- Writeback by a requester whose dest is not busy (single-cycle ALU path) is legal and does not affect the scoreboard.
- No backpressure exists from the register file.

Decomposition:
- regfile_pkg holds DATA_WIDTH, ADDRESS_WIDTH, NUM_REGS, NUM_REQ, the requester index constants (REQ_ALU=0, REQ_LSU=1, REQ_MDU=2), and a wb_req_t struct {dest, data}.
- One sub-module, rr_arbiter (parameter NUM_REQ): inputs req_valid and rr_ptr; outputs a one-hot grant and the grant index.
- Scoreboard and output register stay in the top module.

Test Plan:
- Reset: assert rst for 2 cycles with req_valid=3'b111 -> req_ready=0, rg_wrt_en=0, busy_vec=0, iss_ready=0.
- Round-robin: req_valid=3'b111 held with dests 5/6/7 and data A/B/C -> grants 0,1,2,0 on successive cycles; rg_wrt_en=1 with (5,A),(6,B),(7,C) one cycle after each grant.
- x0 drop: only LSU requests dest=0, data=0xDEAD -> req_ready[1]=1, next cycle rg_wrt_en=0, and reading x0 from the register file returns 0.
- Scoreboard RAW: issue dest=10 -> busy[10]=1 and rs1_addr=10 gives rs1_busy=1. MDU requests dest 10 data 0x1234 -> rs1_busy=0 in the grant cycle, and the register file reads 0x1234 the next cycle.
- WAW/back-to-back: busy[12]=1 with iss_dest=12 and no grant -> iss_ready=0. In the cycle LSU is granted dest 12, iss_dest=12 -> iss_ready=1 and busy[12] remains 1 afterward.
- Reset mid-operation: busy[3]=1 and LSU request pending, assert rst -> busy_vec=0, rg_wrt_en=0, rr_ptr=0. After rst is released, the first grant goes to index 0 when all requesters are valid.
